// File: rtl/lcd_bus_sequencer.sv
// 8080-style LCD write-cycle sequencer fed by SPI command-bus register writes.
// Optional macro LCD_BURST_CS_EN keeps CS low across back-to-back queued bytes.
module lcd_bus_sequencer #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int CMD_ADDR     = 2,
  parameter int DAT_ADDR     = 3,
  parameter int RES_ADDR     = 5,
  parameter int DEPTH_W      = 2,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 1,
  parameter int RES_LOW_CYC  = 16,
  parameter int RES_WAIT_CYC = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] commAddr,
  input  logic [DATA_W-1:0] commData,
  output logic              busy,
  output logic              full,
  output logic              ovf,
  output logic [DATA_W-1:0] lcd_d,
  output logic              lcd_rs,
  output logic              lcd_wr,
  output logic              lcd_rd,
  output logic              lcd_cs,
  output logic              lcd_res
);

  localparam int DEPTH   = 1 << DEPTH_W;
  localparam int M1      = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int M2      = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
  localparam int M3      = (M2 > RES_LOW_CYC) ? M2 : RES_LOW_CYC;
  localparam int CNT_MAX = (M3 > RES_WAIT_CYC) ? M3 : RES_WAIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W-1:0]  L_CMD  = ADDR_W'(CMD_ADDR);
  localparam logic [ADDR_W-1:0]  L_DAT  = ADDR_W'(DAT_ADDR);
  localparam logic [ADDR_W-1:0]  L_RES  = ADDR_W'(RES_ADDR);
  localparam logic [DEPTH_W:0]   L_FULL = (DEPTH_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RES_LOW,
    ST_RES_WAIT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_W:0]     r_mem [DEPTH];
  logic [DEPTH_W-1:0]  r_wptr, r_rptr;
  logic [DEPTH_W:0]    r_count, w_count_nxt;
  logic                r_res_pend;
  logic                r_ovf, r_busy, r_full;
  logic [DATA_W-1:0]   r_d;
  logic                r_rs, r_wr, r_cs, r_res;

  logic                w_push_req, w_res_req, w_full_now, w_push_ok;
  logic                w_can_pop, w_pop, w_take_res, w_cnt_zero;
  logic                w_cs_nxt, w_wr_nxt, w_res_nxt;
  logic [DATA_W:0]     w_head;

  assign w_push_req  = wrEn && ((commAddr == L_CMD) || (commAddr == L_DAT));
  assign w_res_req   = wrEn && (commAddr == L_RES);
  assign w_full_now  = (r_count == L_FULL);
  assign w_push_ok   = w_push_req && !w_full_now;
  // A reset request flushes the queue this edge, so it also blocks any pop.
  assign w_can_pop   = (r_count != '0) && !w_res_req;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_head      = r_mem[r_rptr];
  assign w_count_nxt = r_count + (DEPTH_W+1)'(w_push_ok) - (DEPTH_W+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? '0 : r_cnt - 1'b1;
    w_pop       = 1'b0;
    w_take_res  = 1'b0;
    w_cs_nxt    = r_cs;
    w_wr_nxt    = r_wr;
    w_res_nxt   = r_res;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (r_res_pend) begin
          w_take_res  = 1'b1;
          w_state_nxt = ST_RES_LOW;
          w_cnt_nxt   = CNT_W'(RES_LOW_CYC - 1);
          w_res_nxt   = 1'b0;
          w_cs_nxt    = 1'b1;
        end else if (w_can_pop) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          w_cs_nxt    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = CNT_W'(STROBE_CYC - 1);
          w_wr_nxt    = 1'b0;
        end
      end
      ST_STROBE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
          w_wr_nxt    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
`ifdef LCD_BURST_CS_EN
          if (!r_res_pend && w_can_pop) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_cs_nxt    = 1'b1;
          end
`else
          w_state_nxt = ST_IDLE;
          w_cs_nxt    = 1'b1;
`endif
        end
      end
      ST_RES_LOW: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_RES_WAIT;
          w_cnt_nxt   = CNT_W'(RES_WAIT_CYC - 1);
          w_res_nxt   = 1'b1;
        end
      end
      ST_RES_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = 1'b1;
        w_wr_nxt    = 1'b1;
        w_res_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cs    <= 1'b1;
      r_wr    <= 1'b1;
      r_res   <= 1'b1;
      r_rs    <= 1'b0;
      r_d     <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cs    <= w_cs_nxt;
      r_wr    <= w_wr_nxt;
      r_res   <= w_res_nxt;
      r_busy  <= (r_state != ST_IDLE) || (r_count != '0);
      if (w_pop) begin
        r_rs <= w_head[DATA_W];
        r_d  <= w_head[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_res_pend <= 1'b0;
    end else if (w_res_req) begin
      r_rptr     <= r_wptr;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_res_pend <= 1'b1;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_FULL);
      if (w_push_req && w_full_now) r_ovf <= 1'b1;
      if (w_take_res) r_res_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= {(commAddr == L_DAT), commData};
  end

  assign busy    = r_busy;
  assign full    = r_full;
  assign ovf     = r_ovf;
  assign lcd_d   = r_d;
  assign lcd_rs  = r_rs;
  assign lcd_wr  = r_wr;
  assign lcd_rd  = 1'b1;
  assign lcd_cs  = r_cs;
  assign lcd_res = r_res;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: directed scenarios plus random traffic against a
// timer/queue reference model of the bus behaviour.
module tb_lcd_bus_sequencer;
  localparam int S  = 1;
  localparam int ST = 2;
  localparam int H  = 1;
  localparam int RL = 16;
  localparam int RW = 32;
  localparam int WT = S + ST + H;
  localparam int RT = RL + RW;
`ifdef LCD_BURST_CS_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wrEn;
  logic [2:0] commAddr;
  logic [7:0] commData;
  logic       busy, full, ovf;
  logic [7:0] lcd_d;
  logic       lcd_rs, lcd_wr, lcd_rd, lcd_cs, lcd_res;

  always #5 clk = ~clk;

  lcd_bus_sequencer #(
    .DATA_W(8), .ADDR_W(3), .CMD_ADDR(2), .DAT_ADDR(3), .RES_ADDR(5),
    .DEPTH_W(2), .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H),
    .RES_LOW_CYC(RL), .RES_WAIT_CYC(RW)
  ) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .commAddr(commAddr), .commData(commData),
    .busy(busy), .full(full), .ovf(ovf), .lcd_d(lcd_d), .lcd_rs(lcd_rs),
    .lcd_wr(lcd_wr), .lcd_rd(lcd_rd), .lcd_cs(lcd_cs), .lcd_res(lcd_res)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a byte queue plus one activity (0 none, 1 write, 2 reset) aged in cycles.
  logic [8:0] mq[$];
  bit         m_ovf, m_pend, m_busy, m_full;
  int         m_kind, m_age;
  logic [8:0] m_cur;

  int cs_low, wr_low, wr_pulses, res_low, busy_cnt, cur_run, max_run;
  logic [8:0] last_byte;
  logic       prev_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs_vec();
    return {lcd_cs, lcd_wr, lcd_rd, lcd_rs, lcd_d, lcd_res, busy, full, ovf};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic cs, wr, res;
    cs  = !(m_kind == 1);
    wr  = !(m_kind == 1 && m_age >= S && m_age < S + ST);
    res = !(m_kind == 2 && m_age < RL);
    return {cs, wr, 1'b1, m_cur[8], m_cur[7:0], res, m_busy, m_full, m_ovf};
  endfunction

  task automatic model_step();
    bit push_req, res_req, pend0, take;
    int size0, total;
    if (!rst) begin
      mq.delete();
      m_ovf = 0; m_pend = 0; m_busy = 0; m_full = 0;
      m_kind = 0; m_age = 0; m_cur = '0;
      return;
    end
    push_req = wrEn && (commAddr == 3'd2 || commAddr == 3'd3);
    res_req  = wrEn && (commAddr == 3'd5);
    size0    = mq.size();
    pend0    = m_pend;
    take     = 0;
    m_busy   = (m_kind != 0) || (size0 != 0);
    total    = (m_kind == 1) ? WT : (m_kind == 2) ? RT : 0;
    if (m_kind != 0 && m_age < total - 1) begin
      m_age++;
    end else if (m_kind == 0 && pend0) begin
      m_kind = 2; m_age = 0; take = 1;
    end else if ((m_kind == 0 || (BURST && m_kind == 1)) && !pend0 && size0 != 0 && !res_req) begin
      m_cur = mq.pop_front(); m_kind = 1; m_age = 0;
    end else begin
      m_kind = 0;
    end
    if (take) m_pend = 0;
    if (res_req) begin
      mq.delete(); m_ovf = 0; m_pend = 1;
    end
    if (push_req) begin
      if (size0 == 4) m_ovf = 1;
      else mq.push_back({commAddr == 3'd3, commData});
    end
    m_full = (mq.size() == 4);
  endtask

  task automatic clear_stats();
    cs_low = 0; wr_low = 0; wr_pulses = 0; res_low = 0; busy_cnt = 0;
    cur_run = 0; max_run = 0; last_byte = '0;
  endtask

  task automatic tick(input logic w, input logic [2:0] a, input logic [7:0] d);
    wrEn = w; commAddr = a; commData = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pins", 32'(obs_vec()), 32'(exp_vec()));
    if (!lcd_cs) begin
      cs_low++; cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      last_byte = {lcd_rs, lcd_d};
    end else begin
      cur_run = 0;
    end
    if (!lcd_wr) wr_low++;
    if (prev_wr && !lcd_wr) wr_pulses++;
    prev_wr = lcd_wr;
    if (!lcd_res) res_low++;
    if (busy) busy_cnt++;
    wrEn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    logic [2:0] addr_list [5];
    int r;
    addr_list = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd7};
    rst = 1'b0; wrEn = 1'b0; commAddr = '0; commData = '0; prev_wr = 1'b1;
    clear_stats();

    idle(3);
    check("reset_state", 32'(obs_vec()), 32'h0000_E008);
    rst = 1'b1;
    idle(2);

    clear_stats();
    tick(1'b1, 3'd2, 8'h2C);
    idle(8);
    check("single_cs_low", 32'(cs_low), 32'd4);
    check("single_wr_low", 32'(wr_low), 32'd2);
    check("single_byte", 32'(last_byte), 32'h02C);

    clear_stats();
    for (int i = 1; i <= 5; i++) tick(1'b1, 3'd3, 8'(i));
    idle(30);
    check("ovf5_pulses", 32'(wr_pulses), 32'd5);
    check("ovf5_last", 32'(last_byte), 32'h105);
    check("ovf5_flag", 32'(ovf), 32'd0);

    clear_stats();
    tick(1'b1, 3'd3, 8'h10);
    for (int i = 0; i < 5; i++) tick(1'b1, 3'd3, 8'(8'h11 + i));
    idle(40);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_pulses", 32'(wr_pulses), 32'd5);
    check("ovf_last", 32'(last_byte), 32'h114);

    clear_stats();
    tick(1'b1, 3'd3, 8'hA0);
    tick(1'b1, 3'd3, 8'hA1);
    tick(1'b1, 3'd3, 8'hA2);
    tick(1'b1, 3'd5, 8'h00);
    tick(1'b1, 3'd2, 8'hB0);
    idle(70);
    check("res_pulses", 32'(wr_pulses), 32'd2);
    check("res_low", 32'(res_low), 32'd16);
    check("res_last", 32'(last_byte), 32'h0B0);
    check("res_ovf_clr", 32'(ovf), 32'd0);

    clear_stats();
    foreach (addr_list[i]) tick(1'b1, addr_list[i], 8'($urandom));
    idle(5);
    check("filter_cs", 32'(cs_low), 32'd0);
    check("filter_busy", 32'(busy_cnt), 32'd0);

    clear_stats();
    tick(1'b1, 3'd2, 8'h55);
    idle(1);
    rst = 1'b0;
    idle(1);
    check("sync_rst_state", 32'(obs_vec()), 32'h0000_E008);
    rst = 1'b1;
    tick(1'b1, 3'd3, 8'h66);
    idle(8);
    check("sync_rst_pulses", 32'(wr_pulses), 32'd1);
    check("sync_rst_byte", 32'(last_byte), 32'h166);

    clear_stats();
    tick(1'b1, 3'd2, 8'hC1);
    tick(1'b1, 3'd3, 8'hC2);
    tick(1'b1, 3'd3, 8'hC3);
    idle(20);
    check("burst_run", 32'(max_run), BURST ? 32'd12 : 32'd4);
    check("burst_pulses", 32'(wr_pulses), 32'd3);

    for (int n = 0; n < 800; n++) begin
      logic [2:0] a;
      r = $urandom_range(0, 99);
      if (r < 3)       a = 3'd5;
      else if (r < 50) a = 3'd3;
      else if (r < 80) a = 3'd2;
      else             a = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 499) != 0);
      tick($urandom_range(0, 99) < 40, a, 8'($urandom));
      rst = 1'b1;
    end
    idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
